oled_refresh_ctrl: RTL and testbench
====================================

Name: oled_refresh_ctrl

Overview:
Frame-refresh sequencer for the OLED panel. On START it walks every page of a byte-wide framebuffer RAM and, per page, issues the page/column addressing commands and then all column data bytes. Each byte goes through the shared SPI byte engine using its start/done handshake and 10-bit data word. It sits beside the init sequencer under the OLED top; the top grants it the SPI engine only after init completes.

Parameters:
PAGES, 8, number of display pages (8 rows each)
COLS, 128, data bytes per page
COL_OFFSET, 0, panel column offset (2 for SH1106-type glass), 0..255
AW, 10, framebuffer address width; must satisfy 2^AW >= PAGES*COLS

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  request one full frame refresh; sampled only in IDLE
BUSY  out  1  high from the cycle after START is accepted until DONE
DONE  out  1  one-cycle pulse when the last data byte's spi_done is seen
fb_rd_en  out  1  framebuffer read strobe
fb_addr  out  AW  framebuffer address = page*COLS + col
fb_data  in  8  framebuffer read data, valid exactly 1 cycle after fb_rd_en
spi_start  out  1  one-cycle pulse launching one SPI byte
spi_data  out  10  [9]=DC (0 command, 1 data), [8]=0 reserved, [7:0]=byte
spi_done  in  1  one-cycle pulse from the SPI engine when its byte completes

Behaviour:
- Reset (async, RST_N low): state IDLE; BUSY=0, DONE=0, fb_rd_en=0, fb_addr=0, spi_start=0, spi_data=0; page and col counters = 0. Reset mid-frame aborts immediately; no resume.
- States: IDLE, CMD, CMD_WAIT, FETCH, FETCH_WAIT, DATA, DATA_WAIT, FIN.
- IDLE: when START=1, go to CMD with page=0, cmd_idx=0. START in any other state is ignored, not queued.
- CMD: drive spi_data and pulse spi_start for one cycle, then go to CMD_WAIT. Command bytes by cmd_idx:
  - 0: {2'b00, 8'hB0 | page}
  - 1: {2'b00, 8'h00 | COL_OFFSET[3:0]}
  - 2: {2'b00, 8'h10 | COL_OFFSET[7:4]}
- CMD_WAIT: hold spi_data. On spi_done: if cmd_idx<2, increment it and go to CMD; else col=0 and go to FETCH.
- FETCH: fb_rd_en=1 for one cycle with fb_addr=page*COLS+col, then go to FETCH_WAIT.
- FETCH_WAIT: capture fb_data, go to DATA.
- DATA: spi_data={1'b1,1'b0,captured byte}; pulse spi_start; go to DATA_WAIT.
- DATA_WAIT: on spi_done:
  - col<COLS-1: col+1, go to FETCH.
  - else if page<PAGES-1: page+1, cmd_idx=0, go to CMD.
  - else go to FIN.
- FIN: DONE=1 for one cycle, BUSY goes 0 the same cycle, then go to IDLE.
- spi_start is never asserted while a byte is outstanding: at most one transaction in flight.
- spi_done outside CMD_WAIT/DATA_WAIT is ignored.
- spi_data holds its value from the spi_start cycle until the matching spi_done.
- Latency, with START at cycle 0: BUSY=1 and spi_start=1 with spi_data=10'h0B0 at cycle 1.
- Gap from spi_done to the next command's spi_start: 1 cycle. Gap from spi_done to the next data byte's spi_start: 3 cycles (FETCH, FETCH_WAIT, DATA).
- Per frame: PAGES*(3+COLS) spi_start pulses, 1048 at defaults.
- Counter widths: page is clog2(PAGES); col is clog2(COLS). Address product truncated to AW.

Decomposition:
- Shared package oled_pkg holds:
  - SPI word field indices (DC_BIT=9).
  - Command opcodes CMD_PAGE=8'hB0, CMD_COL_LO=8'h00, CMD_COL_HI=8'h10.
  - State encoding for this block.
- oled_pkg is also used by the init sequencer.
- No sub-module; the page/col counters and FSM stay in one module.

Test Plan:
- Model SPI engine asserting spi_done 20 cycles after each spi_start; pulse START -> exactly 1048 spi_start pulses, then one DONE pulse. First 4 words: 10'h0B0, 10'h000, 10'h010, then data byte 0.
- Framebuffer preloaded with addr[7:0] -> page 3 data words = {2'b10, (384+col)&8'hFF} for col 0..127. Page 3 command word = 10'h0B3. fb_addr sequence 384..511.
- COL_OFFSET=2 -> second and third command words every page are 10'h002 and 10'h010.
- START held high throughout and re-pulsed while BUSY -> exactly one frame is sent. A second START after DONE starts a new frame with 10'h0B0.
- RST_N low for 1 cycle while in DATA_WAIT on page 5 -> all outputs 0 asynchronously. No spi_start until the next START, then the frame restarts at page 0.
- Spurious spi_done in IDLE and in FETCH_WAIT -> no state change and no extra spi_start. Transaction count stays 1048.

Source files
------------

// File: rtl/oled_pkg.sv
// -----------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the OLED controller blocks (init sequencer and frame
// refresh sequencer):
//   - SPI byte-engine word layout: [9]=DC (0 command, 1 data), [8]=reserved,
//     [7:0]=byte
//   - SSD1306/SH1106 addressing command opcodes
//   - state encoding of the frame refresh sequencer
//   - helpers that build command and data words for the SPI engine
// -----------------------------------------------------------------------------
package oled_pkg;

    // SPI word layout
    localparam int SPI_W   = 10;
    localparam int DC_BIT  = 9;
    localparam int RSV_BIT = 8;

    typedef logic [SPI_W-1:0] spi_word_t;

    // Addressing command opcodes; the low nibble carries the argument
    localparam logic [7:0] CMD_PAGE   = 8'hB0;
    localparam logic [7:0] CMD_COL_LO = 8'h00;
    localparam logic [7:0] CMD_COL_HI = 8'h10;

    // Frame refresh sequencer states
    typedef enum logic [2:0] {
        RF_IDLE       = 3'd0,
        RF_CMD        = 3'd1,
        RF_CMD_WAIT   = 3'd2,
        RF_FETCH      = 3'd3,
        RF_FETCH_WAIT = 3'd4,
        RF_DATA       = 3'd5,
        RF_DATA_WAIT  = 3'd6,
        RF_FIN        = 3'd7
    } refresh_state_e;

    // Command word: DC=0, reserved=0
    function automatic spi_word_t spi_cmd_word(input logic [7:0] b);
        spi_word_t w;
        w          = '0;
        w[7:0]     = b;
        return w;
    endfunction

    // Data word: DC=1, reserved=0
    function automatic spi_word_t spi_data_word(input logic [7:0] b);
        spi_word_t w;
        w          = '0;
        w[DC_BIT]  = 1'b1;
        w[7:0]     = b;
        return w;
    endfunction

endpackage : oled_pkg

// File: rtl/oled_refresh_ctrl_if.sv
// -----------------------------------------------------------------------------
// oled_refresh_ctrl_if
// Bundles the two side buses of the frame refresh sequencer:
//   framebuffer read port : fb_rd_en, fb_addr[AW-1:0] (to RAM), fb_data[7:0]
//                           (from RAM, valid one cycle after fb_rd_en)
//   SPI byte engine       : spi_start, spi_data[9:0] (to engine), spi_done
//                           (from engine, one-cycle pulse per finished byte)
// Modports:
//   master : the sequencer side
//   slave  : the RAM / SPI engine side
// -----------------------------------------------------------------------------
interface oled_refresh_ctrl_if #(
    parameter int AW = 10
);
    import oled_pkg::*;

    logic          fb_rd_en;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;

    logic          spi_start;
    spi_word_t     spi_data;
    logic          spi_done;

    modport master (
        output fb_rd_en,
        output fb_addr,
        input  fb_data,
        output spi_start,
        output spi_data,
        input  spi_done
    );

    modport slave (
        input  fb_rd_en,
        input  fb_addr,
        output fb_data,
        input  spi_start,
        input  spi_data,
        output spi_done
    );

endinterface : oled_refresh_ctrl_if

// File: rtl/oled_refresh_ctrl.sv
// -----------------------------------------------------------------------------
// oled_refresh_ctrl
// Frame refresh sequencer. On START it walks every page of the byte-wide
// framebuffer; for each page it sends the three addressing commands (page,
// column low nibble, column high nibble) followed by all COLS data bytes, one
// byte at a time through the shared SPI byte engine.
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset (aborts a frame, no resume)
//   START  in   request one frame refresh, sampled only while idle
//   BUSY   out  high from the cycle after START is accepted until DONE
//   DONE   out  one-cycle pulse when the last data byte has completed
//   bus    master modport of oled_refresh_ctrl_if (framebuffer + SPI engine)
//
// Parameters:
//   PAGES      number of display pages
//   COLS       data bytes per page
//   COL_OFFSET panel column offset, 0..255 (2 for SH1106 glass)
//   AW         framebuffer address width; 2**AW must cover PAGES*COLS
//
// Only one SPI byte is ever in flight: spi_start is raised only from RF_CMD or
// RF_DATA, and both are left solely through a *_WAIT state that waits for
// spi_done. spi_done in any other state is ignored.
// -----------------------------------------------------------------------------
module oled_refresh_ctrl
    import oled_pkg::*;
#(
    parameter int PAGES      = 8,
    parameter int COLS       = 128,
    parameter int COL_OFFSET = 0,
    parameter int AW         = 10
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    output logic                 BUSY,
    output logic                 DONE,
    oled_refresh_ctrl_if.master  bus
);

    localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int CW = (COLS  > 1) ? $clog2(COLS)  : 1;

    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [7:0]    COL_OFF8  = 8'(COL_OFFSET);

    // Command bytes sent before each page's data
    localparam logic [1:0] CMD_IDX_LAST = 2'd2;

    refresh_state_e state_q,   state_d;
    logic [PW-1:0]  page_q,    page_d;
    logic [CW-1:0]  col_q,     col_d;
    logic [1:0]     cmd_idx_q, cmd_idx_d;
    logic [AW-1:0]  fb_addr_q, fb_addr_d;
    spi_word_t      spi_data_q, spi_data_d;

    // Addressing command for a given position in the per-page preamble
    function automatic spi_word_t page_cmd(input logic [1:0] idx, input logic [PW-1:0] pg);
        logic [7:0] b;
        case (idx)
            2'd0:    b = CMD_PAGE   | 8'(pg);
            2'd1:    b = CMD_COL_LO | {4'h0, COL_OFF8[3:0]};
            default: b = CMD_COL_HI | {4'h0, COL_OFF8[7:4]};
        endcase
        return spi_cmd_word(b);
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned; a missing default would infer a latch.
        state_d    = state_q;
        page_d     = page_q;
        col_d      = col_q;
        cmd_idx_d  = cmd_idx_q;
        fb_addr_d  = fb_addr_q;
        spi_data_d = spi_data_q;

        unique case (state_q)
            RF_IDLE: begin
                if (START) begin
                    page_d    = '0;
                    cmd_idx_d = '0;
                    state_d   = RF_CMD;
                end
            end

            RF_CMD: state_d = RF_CMD_WAIT;

            RF_CMD_WAIT: begin
                if (bus.spi_done) begin
                    if (cmd_idx_q != CMD_IDX_LAST) begin
                        cmd_idx_d = cmd_idx_q + 2'd1;
                        state_d   = RF_CMD;
                    end else begin
                        col_d   = '0;
                        state_d = RF_FETCH;
                    end
                end
            end

            RF_FETCH: state_d = RF_FETCH_WAIT;

            // RAM data is valid now; it goes straight into the SPI word
            // register, which then holds it for the whole byte transfer.
            RF_FETCH_WAIT: begin
                spi_data_d = spi_data_word(bus.fb_data);
                state_d    = RF_DATA;
            end

            RF_DATA: state_d = RF_DATA_WAIT;

            RF_DATA_WAIT: begin
                if (bus.spi_done) begin
                    if (col_q != COL_LAST) begin
                        col_d   = col_q + CW'(1);
                        state_d = RF_FETCH;
                    end else if (page_q != PAGE_LAST) begin
                        page_d    = page_q + PW'(1);
                        cmd_idx_d = '0;
                        state_d   = RF_CMD;
                    end else begin
                        state_d = RF_FIN;
                    end
                end
            end

            RF_FIN: state_d = RF_IDLE;

            default: state_d = RF_IDLE;
        endcase

        // Bus values are prepared on entry to the issuing state so they are
        // already registered when spi_start / fb_rd_en is decoded high.
        if (state_d == RF_CMD) begin
            spi_data_d = page_cmd(cmd_idx_d, page_d);
        end
        if (state_d == RF_FETCH) begin
            fb_addr_d = AW'(32'(page_d) * COLS + 32'(col_d));
        end
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= RF_IDLE;
            page_q     <= '0;
            col_q      <= '0;
            cmd_idx_q  <= '0;
            fb_addr_q  <= '0;
            spi_data_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            state_q    <= state_d;
            page_q     <= page_d;
            col_q      <= col_d;
            cmd_idx_q  <= cmd_idx_d;
            fb_addr_q  <= fb_addr_d;
            spi_data_q <= spi_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: strobes are decoded from the registered state, so they all
    // read 0 while reset is asserted.
    // -------------------------------------------------------------------------
    assign bus.spi_start = (state_q == RF_CMD) || (state_q == RF_DATA);
    assign bus.spi_data  = spi_data_q;
    assign bus.fb_rd_en  = (state_q == RF_FETCH);
    assign bus.fb_addr   = fb_addr_q;

    assign BUSY = (state_q != RF_IDLE) && (state_q != RF_FIN);
    assign DONE = (state_q == RF_FIN);

endmodule : oled_refresh_ctrl

// File: tb/tb_oled_refresh_ctrl.sv
// -----------------------------------------------------------------------------
// tb_oled_refresh_ctrl
// Two sequencers share clock and reset: dut_a (COL_OFFSET=0) and dut_b
// (COL_OFFSET=2). Each sees a framebuffer model holding addr[7:0] with one
// cycle read latency and an SPI engine model that answers every spi_start with
// spi_done 20 cycles later. The engine model also flags overlapping starts and
// spi_data changing while a byte is outstanding.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_oled_refresh_ctrl;
    import oled_pkg::*;

    localparam int PAGES       = 8;
    localparam int COLS        = 128;
    localparam int AW          = 10;
    localparam int SPI_LAT     = 20;
    localparam int WPP         = 3 + COLS;       // SPI words per page
    localparam int FRAME_WORDS = PAGES * WPP;    // 1048

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, start_b;
    logic busy_a, busy_b, done_a, done_b;

    oled_refresh_ctrl_if #(.AW(AW)) ifa ();
    oled_refresh_ctrl_if #(.AW(AW)) ifb ();

    oled_refresh_ctrl #(
        .PAGES(PAGES), .COLS(COLS), .COL_OFFSET(0), .AW(AW)
    ) dut_a (
        .CLK(clk), .RST_N(rst_n), .START(start_a),
        .BUSY(busy_a), .DONE(done_a), .bus(ifa)
    );

    oled_refresh_ctrl #(
        .PAGES(PAGES), .COLS(COLS), .COL_OFFSET(2), .AW(AW)
    ) dut_b (
        .CLK(clk), .RST_N(rst_n), .START(start_b),
        .BUSY(busy_b), .DONE(done_b), .bus(ifb)
    );

    always #5 clk = ~clk;

    // DUT-side views, indexed by instance
    logic          s_start [2];
    logic          s_rd    [2];
    logic          s_done  [2];
    logic          s_busy  [2];
    logic [9:0]    s_data  [2];
    logic [AW-1:0] s_addr  [2];

    assign s_start[0] = ifa.spi_start;  assign s_start[1] = ifb.spi_start;
    assign s_rd[0]    = ifa.fb_rd_en;   assign s_rd[1]    = ifb.fb_rd_en;
    assign s_done[0]  = done_a;         assign s_done[1]  = done_b;
    assign s_busy[0]  = busy_a;         assign s_busy[1]  = busy_b;
    assign s_data[0]  = ifa.spi_data;   assign s_data[1]  = ifb.spi_data;
    assign s_addr[0]  = ifa.fb_addr;    assign s_addr[1]  = ifb.fb_addr;

    // Model-driven inputs
    logic [7:0] fb_q     [2] = '{8'hEE, 8'hEE};
    logic       mdl_done [2] = '{1'b0, 1'b0};
    logic       inj_fw   = 1'b0;   // spurious spi_done during FETCH_WAIT
    logic       inj_idle = 1'b0;   // spurious spi_done while idle
    logic       inj_next = 1'b0;
    int         inj_left = 0;

    assign ifa.fb_data  = fb_q[0];
    assign ifb.fb_data  = fb_q[1];
    assign ifa.spi_done = mdl_done[0] | inj_fw | inj_idle;
    assign ifb.spi_done = mdl_done[1];

    // Model state and scoreboards
    int            cnt          [2] = '{0, 0};
    logic [9:0]    hold         [2] = '{10'h0, 10'h0};
    logic          rd_pend      [2] = '{1'b0, 1'b0};
    logic [AW-1:0] rd_adr       [2] = '{'0, '0};
    int            overlap_err  [2] = '{0, 0};
    int            hold_err     [2] = '{0, 0};
    int            done_busy_err[2] = '{0, 0};
    int            done_cnt     [2] = '{0, 0};
    logic [9:0]    words_a[$];
    logic [9:0]    words_b[$];
    logic [AW-1:0] addr_a[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Framebuffer, SPI engine and monitor, all sampled 1 ns after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            inj_fw   = inj_next;
            inj_next = 1'b0;
            for (int i = 0; i < 2; i++) begin
                // RAM: data for the read issued last cycle, junk otherwise
                fb_q[i]    = rd_pend[i] ? rd_adr[i][7:0] : 8'hEE;
                rd_pend[i] = s_rd[i];
                rd_adr[i]  = s_addr[i];
                if (i == 0 && s_rd[i] === 1'b1) addr_a.push_back(s_addr[i]);

                // SPI engine
                mdl_done[i] = 1'b0;
                if (!rst_n) begin
                    cnt[i] = 0;
                end else if (cnt[i] > 0) begin
                    if (s_data[i] !== hold[i]) hold_err[i]++;
                    cnt[i]--;
                    if (cnt[i] == 0) mdl_done[i] = 1'b1;
                end
                if (s_start[i] === 1'b1) begin
                    if (cnt[i] != 0) overlap_err[i]++;
                    cnt[i]  = SPI_LAT;
                    hold[i] = s_data[i];
                    if (i == 0) words_a.push_back(s_data[i]);
                    else        words_b.push_back(s_data[i]);
                end

                if (s_done[i] === 1'b1) begin
                    done_cnt[i]++;
                    if (s_busy[i] !== 1'b0) done_busy_err[i]++;
                end
            end
            if (s_rd[0] === 1'b1 && inj_left > 0 && words_a.size() > 300) begin
                inj_next = 1'b1;
                inj_left--;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int mark;

        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) tick();

        check("rst_busy",      busy_a,        1'b0);
        check("rst_done",      done_a,        1'b0);
        check("rst_fb_rd_en",  ifa.fb_rd_en,  1'b0);
        check("rst_fb_addr",   ifa.fb_addr,   10'h0);
        check("rst_spi_start", ifa.spi_start, 1'b0);
        check("rst_spi_data",  ifa.spi_data,  10'h0);

        rst_n = 1'b1;
        repeat (2) tick();

        // Spurious spi_done while idle
        inj_idle = 1'b1;
        tick();
        inj_idle = 1'b0;
        repeat (5) tick();
        check("idle_spurious_starts", words_a.size(), 0);
        check("idle_spurious_busy",   busy_a,         1'b0);

        // Frame 1: a holds START high, b re-pulses START while busy
        inj_left = 3;
        start_a  = 1'b1;
        start_b  = 1'b1;
        tick();
        start_b  = 1'b0;
        check("lat_busy",      busy_a,        1'b1);
        check("lat_spi_start", ifa.spi_start, 1'b1);
        check("lat_spi_data",  ifa.spi_data,  10'h0B0);

        fork
            begin : run_a
                bit got_a;
                got_a = 1'b0;
                for (int n = 0; n < 40000 && !got_a; n++) begin
                    tick();
                    if (done_a) begin
                        got_a   = 1'b1;
                        start_a = 1'b0;
                    end
                end
                start_a = 1'b0;
                check("f1_a_done_seen", got_a, 1'b1);
            end
            begin : run_b
                bit got_b;
                got_b = 1'b0;
                for (int n = 0; n < 40000 && !got_b; n++) begin
                    tick();
                    if (done_b) begin
                        got_b   = 1'b1;
                        start_b = 1'b0;
                    end else begin
                        start_b = (n % 997 == 500);
                    end
                end
                start_b = 1'b0;
                check("f1_b_done_seen", got_b, 1'b1);
            end
        join
        repeat (50) tick();

        check("f1_a_starts",       words_a.size(),   FRAME_WORDS);
        check("f1_a_done_pulses",  done_cnt[0],      1);
        check("f1_a_overlap",      overlap_err[0],   0);
        check("f1_a_hold",         hold_err[0],      0);
        check("f1_a_busy_at_done", done_busy_err[0], 0);
        check("f1_a_busy_after",   busy_a,           1'b0);
        check("f1_a_fb_reads",     addr_a.size(),    PAGES * COLS);
        if (words_a.size() >= FRAME_WORDS) begin
            check("f1_a_word0", words_a[0], 10'h0B0);
            check("f1_a_word1", words_a[1], 10'h000);
            check("f1_a_word2", words_a[2], 10'h010);
            check("f1_a_word3", words_a[3], 10'h200);
            check("f1_a_p3_cmd", words_a[3 * WPP], 10'h0B3);
            for (int c = 0; c < COLS; c++) begin
                logic [7:0] b;
                b = 8'((384 + c) & 255);
                check($sformatf("f1_a_p3_data%0d", c), words_a[3 * WPP + 3 + c], {2'b10, b});
            end
            check("f1_a_p7_cmd", words_a[7 * WPP], 10'h0B7);
            check("f1_a_last",   words_a[FRAME_WORDS - 1], 10'h2FF);
        end
        if (addr_a.size() >= PAGES * COLS) begin
            for (int c = 0; c < COLS; c++) begin
                check($sformatf("f1_a_p3_addr%0d", c), addr_a[384 + c], 384 + c);
            end
        end

        check("f1_b_starts",      words_b.size(), FRAME_WORDS);
        check("f1_b_done_pulses", done_cnt[1],    1);
        check("f1_b_overlap",     overlap_err[1], 0);
        check("f1_b_hold",        hold_err[1],    0);
        check("f1_b_busy_after",  busy_b,         1'b0);
        if (words_b.size() >= FRAME_WORDS) begin
            for (int p = 0; p < PAGES; p++) begin
                check($sformatf("f1_b_p%0d_cmd0", p), words_b[p * WPP],     10'h0B0 + 10'(p));
                check($sformatf("f1_b_p%0d_cmd1", p), words_b[p * WPP + 1], 10'h002);
                check($sformatf("f1_b_p%0d_cmd2", p), words_b[p * WPP + 2], 10'h010);
            end
        end

        // Frame 2 on a: new START after DONE, then reset in page 5 DATA_WAIT
        words_a.delete();
        addr_a.delete();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("f2_spi_start", ifa.spi_start, 1'b1);
        check("f2_word0",     ifa.spi_data,  10'h0B0);

        seen = 1'b0;
        for (int n = 0; n < 30000 && !seen; n++) begin
            tick();
            if (words_a.size() >= 5 * WPP + 10) seen = 1'b1;
        end
        check("f2_reach_page5", seen, 1'b1);
        repeat (3) tick();
        if (words_a.size() > 5 * WPP) begin
            check("f2_p5_cmd", words_a[5 * WPP], 10'h0B5);
        end
        check("f2_busy_before_rst", busy_a, 1'b1);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",      busy_a,        1'b0);
        check("arst_done",      done_a,        1'b0);
        check("arst_fb_rd_en",  ifa.fb_rd_en,  1'b0);
        check("arst_fb_addr",   ifa.fb_addr,   10'h0);
        check("arst_spi_start", ifa.spi_start, 1'b0);
        check("arst_spi_data",  ifa.spi_data,  10'h0);
        mark = words_a.size();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (100) tick();
        check("post_rst_no_start", words_a.size(), mark);
        check("post_rst_busy",     busy_a,         1'b0);

        // Restart after reset begins again at page 0
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("restart_word0", ifa.spi_data, 10'h0B0);
        seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            tick();
            if (words_a.size() >= mark + 4) seen = 1'b1;
        end
        check("restart_progress", seen, 1'b1);
        if (words_a.size() >= mark + 4) begin
            check("restart_word1", words_a[mark + 1], 10'h000);
            check("restart_word2", words_a[mark + 2], 10'h010);
            check("restart_word3", words_a[mark + 3], 10'h200);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_oled_refresh_ctrl
